// File: rtl/mem_stage.sv
// Memory-access pipeline stage: halfword load/store over an APB master port,
// pass-through for non-memory results, write-back bus toward the register file.
module mem_stage #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [15:0] alu_result,
  input  logic [15:0] store_data,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        regwrite_in,
  input  logic [2:0]  rd_in,
  output logic [31:0] paddr,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  input  logic [31:0] prdata,
  input  logic        pready,
  output logic [15:0] mmuxout,
  output logic        regwrite,
  output logic [2:0]  rd_out,
  output logic        wb_valid,
  output logic        mem_stall,
  output logic        bus_err
);

  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t          state, next_state;
  logic [CW-1:0]   cnt;
  logic            addr1_q, load_q, rw_q;
  logic [2:0]      rd_q;

  logic            is_mem, illegal, done, abort;
  logic [31:0]     paddr_d, pwdata_d;
  logic [3:0]      pstrb_d;
  logic            pwrite_d, psel_d, penable_d;
  logic [15:0]     mmuxout_d;
  logic [2:0]      rd_out_d;
  logic            regwrite_d, wb_valid_d, bus_err_d;

  assign is_mem  = memRead ^ memWrite;
  assign illegal = memRead & memWrite;
  assign done    = (state == ACCESS) && pready;
  assign abort   = (state == ACCESS) && !pready && (cnt == CW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (valid_in && is_mem) next_state = SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (done || abort) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    paddr_d    = paddr;
    pwdata_d   = pwdata;
    pstrb_d    = pstrb;
    pwrite_d   = pwrite;
    psel_d     = (next_state != IDLE);
    penable_d  = (next_state == ACCESS);
    mmuxout_d  = mmuxout;
    rd_out_d   = rd_out;
    regwrite_d = 1'b0;
    wb_valid_d = 1'b0;
    bus_err_d  = 1'b0;
    case (state)
      IDLE: begin
        if (valid_in) begin
          if (illegal) begin
            wb_valid_d = 1'b1;
            bus_err_d  = 1'b1;
          end else if (is_mem) begin
            paddr_d  = {16'h0000, alu_result[15:2], 2'b00};
            pwrite_d = memWrite;
            pwdata_d = memWrite ? {store_data, store_data} : 32'h0;
            pstrb_d  = !memWrite ? 4'b0000 : (alu_result[1] ? 4'b0011 : 4'b1100);
          end else begin
            mmuxout_d  = alu_result;
            rd_out_d   = rd_in;
            regwrite_d = regwrite_in;
            wb_valid_d = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (done || abort) begin
          paddr_d    = 32'h0;
          pwdata_d   = 32'h0;
          pstrb_d    = 4'b0000;
          pwrite_d   = 1'b0;
          wb_valid_d = 1'b1;
          bus_err_d  = abort;
          rd_out_d   = rd_q;
          if (done && load_q) begin
            mmuxout_d  = addr1_q ? prdata[15:0] : prdata[31:16];
            regwrite_d = rw_q;
          end
        end
      end
      default: ;
    endcase
  end

  // Output, request-latch and timeout-counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      paddr     <= 32'h0;
      pwdata    <= 32'h0;
      pstrb     <= 4'b0000;
      pwrite    <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      mmuxout   <= 16'h0;
      rd_out    <= 3'd0;
      regwrite  <= 1'b0;
      wb_valid  <= 1'b0;
      bus_err   <= 1'b0;
      mem_stall <= 1'b0;
      cnt       <= '0;
      addr1_q   <= 1'b0;
      load_q    <= 1'b0;
      rw_q      <= 1'b0;
      rd_q      <= 3'd0;
    end else begin
      paddr     <= paddr_d;
      pwdata    <= pwdata_d;
      pstrb     <= pstrb_d;
      pwrite    <= pwrite_d;
      psel      <= psel_d;
      penable   <= penable_d;
      mmuxout   <= mmuxout_d;
      rd_out    <= rd_out_d;
      regwrite  <= regwrite_d;
      wb_valid  <= wb_valid_d;
      bus_err   <= bus_err_d;
      mem_stall <= (next_state != IDLE);
      if (state != ACCESS)  cnt <= '0;
      else if (!pready)     cnt <= cnt + CW'(1);
      if (state == IDLE && valid_in && is_mem) begin
        addr1_q <= alu_result[1];
        load_q  <= memRead;
        rw_q    <= regwrite_in;
        rd_q    <= rd_in;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table plus randomized
// transactions checked against a transaction-level reference model.
module tb_mem_stage;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [15:0] alu_result, store_data;
  logic        memRead, memWrite, regwrite_in;
  logic [2:0]  rd_in;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready;
  logic [3:0]  pstrb;
  logic [15:0] mmuxout;
  logic        regwrite, wb_valid, mem_stall, bus_err;
  logic [2:0]  rd_out;

  mem_stage #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .alu_result(alu_result),
    .store_data(store_data), .memRead(memRead), .memWrite(memWrite),
    .regwrite_in(regwrite_in), .rd_in(rd_in), .paddr(paddr), .psel(psel),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata), .pready(pready), .mmuxout(mmuxout), .regwrite(regwrite),
    .rd_out(rd_out), .wb_valid(wb_valid), .mem_stall(mem_stall), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdf, wrf;
    logic [15:0] alu, sd;
    logic [2:0]  rd;
    logic        rw;
    logic [31:0] prd;
    int          waits;
    logic [15:0] e_mux;
    logic [2:0]  e_rd;
    logic        e_rw, e_err;
    logic [31:0] e_paddr, e_pwdata;
    logic [3:0]  e_pstrb;
    logic        e_pwrite;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] m_mux;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: expected outcome of one instruction from the stage rules
  function automatic vec_t model(input vec_t v, input logic [15:0] prev_mux);
    vec_t r = v;
    r.e_mux = prev_mux; r.e_rd = v.rd; r.e_rw = 1'b0; r.e_err = 1'b0;
    r.e_paddr = {16'h0, v.alu & 16'hFFFC};
    r.e_pwrite = v.wrf;
    r.e_pwdata = v.wrf ? {v.sd, v.sd} : 32'h0;
    r.e_pstrb  = !v.wrf ? 4'h0 : ((v.alu % 4) >= 2 ? 4'b0011 : 4'b1100);
    if (v.rdf && v.wrf) r.e_err = 1'b1;
    else if (!v.rdf && !v.wrf) begin r.e_mux = v.alu; r.e_rw = v.rw; end
    else if (v.waits >= int'(TMO)) r.e_err = 1'b1;
    else if (v.rdf) begin
      r.e_mux = ((v.alu % 4) >= 2) ? v.prd[15:0] : v.prd[31:16];
      r.e_rw = v.rw;
    end
    return r;
  endfunction

  task automatic idle_inputs();
    valid_in = 1'b0; memRead = 1'b0; memWrite = 1'b0; regwrite_in = 1'b0;
    alu_result = 16'h0; store_data = 16'h0; rd_in = 3'd0; pready = 1'b0; prdata = 32'h0;
  endtask

  // Apply one instruction from IDLE and check every cycle until it retires
  task automatic run_vec(input vec_t v);
    logic mem;
    mem = v.rdf ^ v.wrf;
    valid_in = 1'b1; memRead = v.rdf; memWrite = v.wrf;
    alu_result = v.alu; store_data = v.sd; rd_in = v.rd; regwrite_in = v.rw;
    pready = 1'(($urandom % 2)); prdata = $urandom;
    step();
    if (mem) begin
      // held/garbage upstream request must be ignored while stalled
      memRead = 1'($urandom % 2); memWrite = 1'($urandom % 2);
      alu_result = 16'($urandom);
      pready = 1'($urandom % 2);
      chk("setup_psel", 32'(psel), 32'd1);
      chk("setup_penable", 32'(penable), 32'd0);
      chk("setup_stall", 32'(mem_stall), 32'd1);
      chk("setup_paddr", paddr, v.e_paddr);
      chk("setup_pwrite", 32'(pwrite), 32'(v.e_pwrite));
      chk("setup_pstrb", 32'(pstrb), 32'(v.e_pstrb));
      if (v.wrf) chk("setup_pwdata", pwdata, v.e_pwdata);
      chk("setup_wb", 32'(wb_valid), 32'd0);
      step();
      for (int i = 0; i < int'(TMO); i++) begin
        chk("acc_psel", 32'(psel), 32'd1);
        chk("acc_penable", 32'(penable), 32'd1);
        chk("acc_stall", 32'(mem_stall), 32'd1);
        chk("acc_paddr", paddr, v.e_paddr);
        chk("acc_pstrb", 32'(pstrb), 32'(v.e_pstrb));
        chk("acc_wb", 32'(wb_valid), 32'd0);
        if (i >= v.waits) begin pready = 1'b1; prdata = v.prd; end
        else begin pready = 1'b0; prdata = $urandom; end
        step();
        valid_in = 1'b0; pready = 1'b0;
        if (i >= v.waits) break;
      end
      chk("done_psel", 32'(psel), 32'd0);
      chk("done_penable", 32'(penable), 32'd0);
      chk("done_paddr", paddr, 32'h0);
      chk("done_pstrb", 32'(pstrb), 32'd0);
      chk("done_pwrite", 32'(pwrite), 32'd0);
      chk("done_pwdata", pwdata, 32'h0);
    end
    valid_in = 1'b0;
    chk("wb_valid", 32'(wb_valid), 32'd1);
    chk("regwrite", 32'(regwrite), 32'(v.e_rw));
    chk("bus_err", 32'(bus_err), 32'(v.e_err));
    chk("mmuxout", 32'(mmuxout), 32'(v.e_mux));
    chk("stall_after", 32'(mem_stall), 32'd0);
    chk("psel_after", 32'(psel), 32'd0);
    if (!v.e_err && (!mem || v.rdf)) chk("rd_out", 32'(rd_out), 32'(v.e_rd));
    step();
    chk("wb_pulse", 32'(wb_valid), 32'd0);
    chk("err_pulse", 32'(bus_err), 32'd0);
    chk("rw_pulse", 32'(regwrite), 32'd0);
  endtask

  vec_t tbl[9];

  function automatic vec_t mk(input logic rdf, input logic wrf, input logic [15:0] alu,
      input logic [15:0] sd, input logic [2:0] rd, input logic rw, input logic [31:0] prd,
      input int waits, input logic [15:0] e_mux, input logic e_rw, input logic e_err,
      input logic [31:0] e_paddr, input logic [3:0] e_pstrb);
    vec_t v;
    v.rdf = rdf; v.wrf = wrf; v.alu = alu; v.sd = sd; v.rd = rd; v.rw = rw;
    v.prd = prd; v.waits = waits; v.e_mux = e_mux; v.e_rd = rd; v.e_rw = e_rw;
    v.e_err = e_err; v.e_paddr = e_paddr; v.e_pstrb = e_pstrb; v.e_pwrite = wrf;
    v.e_pwdata = {sd, sd};
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //        rdf  wrf  alu       sd       rd   rw  prdata        wt  e_mux    rw  err paddr          strb
    tbl[0] = mk(0, 0, 16'h1234, 16'h0,   3'd3, 1, 32'h0,        0, 16'h1234, 1, 0, 32'h0,        4'h0);
    tbl[1] = mk(1, 0, 16'h0040, 16'h0,   3'd5, 1, 32'hAAAA5555, 0, 16'hAAAA, 1, 0, 32'h00000040, 4'h0);
    tbl[2] = mk(0, 1, 16'h0042, 16'hBEEF, 3'd2, 1, 32'h0,       2, 16'hAAAA, 0, 0, 32'h00000040, 4'b0011);
    tbl[3] = mk(1, 0, 16'h0010, 16'h0,   3'd1, 1, 32'h0,       99, 16'hAAAA, 0, 1, 32'h00000010, 4'h0);
    tbl[4] = mk(1, 1, 16'h0020, 16'h0,   3'd4, 1, 32'h0,        0, 16'hAAAA, 0, 1, 32'h0,        4'h0);
    tbl[5] = mk(1, 0, 16'h0043, 16'h0,   3'd7, 1, 32'h12345678, 1, 16'h5678, 1, 0, 32'h00000040, 4'h0);
    tbl[6] = mk(0, 1, 16'h00F1, 16'hCAFE, 3'd6, 1, 32'h0,       3, 16'h5678, 0, 0, 32'h000000F0, 4'b1100);
    tbl[7] = mk(1, 0, 16'hFFFE, 16'h0,   3'd0, 0, 32'h0000ABCD, 0, 16'hABCD, 0, 0, 32'h0000FFFC, 4'h0);
    tbl[8] = mk(0, 0, 16'h5A5A, 16'h0,   3'd1, 0, 32'h0,        0, 16'h5A5A, 0, 0, 32'h0,        4'h0);

    idle_inputs();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_mux", 32'(mmuxout), 32'd0);
    chk("rst_outs", {paddr[15:0], 4'(pstrb), 3'(rd_out), penable, pwrite, regwrite, wb_valid, bus_err, 4'h0}, 32'h0);
    chk("rst_pwdata", pwdata, 32'h0);

    foreach (tbl[i]) run_vec(tbl[i]);

    // Reset asserted during ACCESS discards the request
    valid_in = 1'b1; memRead = 1'b1; alu_result = 16'h0080; rd_in = 3'd5; regwrite_in = 1'b1;
    step();
    valid_in = 1'b0;
    step();
    chk("pre_rst_penable", 32'(penable), 32'd1);
    rst = 1'b1; pready = 1'b1; prdata = 32'h11112222;
    step();
    rst = 1'b0; pready = 1'b0;
    chk("mid_rst_psel", 32'(psel), 32'd0);
    chk("mid_rst_penable", 32'(penable), 32'd0);
    chk("mid_rst_stall", 32'(mem_stall), 32'd0);
    chk("mid_rst_mux", 32'(mmuxout), 32'd0);
    chk("mid_rst_paddr", paddr, 32'h0);
    chk("mid_rst_rd", 32'(rd_out), 32'd0);
    step();
    chk("post_rst_wb", 32'(wb_valid), 32'd0);
    chk("post_rst_err", 32'(bus_err), 32'd0);
    m_mux = 16'h0;
    v = mk(0, 0, 16'h7E57, 16'h0, 3'd6, 1, 32'h0, 0, 16'h7E57, 1, 0, 32'h0, 4'h0);
    run_vec(v);
    m_mux = 16'h7E57;

    // Randomized transactions against the reference model
    for (int n = 0; n < 60; n++) begin
      int k;
      k = int'($urandom_range(0, 9));
      v.rdf = (k >= 2 && k <= 5) || k == 9;
      v.wrf = (k >= 6 && k <= 8) || k == 9;
      v.alu = 16'($urandom); v.sd = 16'($urandom); v.rd = 3'($urandom);
      v.rw = 1'($urandom); v.prd = $urandom; v.waits = int'($urandom_range(0, 5));
      v = model(v, m_mux);
      run_vec(v);
      m_mux = v.e_mux;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
